// File: rtl/sum_accum_12.sv
// Frame accumulator for a 12-bit upstream adder: sums num_terms_i terms and
// presents the result on a valid/ready port. Define SUM_ACCUM_SAT_EN to clamp on overflow.
module sum_accum_12 #(
  parameter int ACC_W = 20
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [7:0]       num_terms_i,
  input  logic [11:0]      sum_i,
  input  logic             sum_valid_i,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             busy_o,
  output logic             err_o
);

  // Result handshake: a transfer completes on any cycle where acc_valid_o and
  // acc_ready_i are both high; acc_o/acc_valid_o hold steady until then.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] accum_q, accum_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       num_q, num_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic [ACC_W:0]   add_full;
  logic [ACC_W-1:0] add_res;
  logic [7:0]       cnt_inc;
  logic             xfer;
  logic             accept;

  assign add_full = {1'b0, accum_q} + {{(ACC_W + 1 - 12){1'b0}}, sum_i};
`ifdef SUM_ACCUM_SAT_EN
  assign add_res  = add_full[ACC_W] ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];
`else
  assign add_res  = add_full[ACC_W-1:0];
`endif
  assign cnt_inc  = cnt_q + 8'd1;
  assign xfer     = valid_q & acc_ready_i;
  // A start is taken from IDLE, or from DONE on the cycle its result leaves.
  assign accept   = start_i & ((state_q == IDLE) | ((state_q == DONE) & xfer));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      accum_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      num_q    <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      accum_q  <= accum_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (num_terms_i == 8'd0) ? DONE : ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (sum_valid_i && (cnt_inc == num_q)) state_d = DONE;
        DONE:    if (xfer) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    accum_d  = accum_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    num_d    = num_q;
    valid_d  = valid_q;
    err_d    = err_q;
    if (accept) begin
      // Any term arriving with the start is dropped without flagging an overrun.
      num_d   = num_terms_i;
      accum_d = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
      if (num_terms_i == 8'd0) begin
        result_d = '0;
        valid_d  = 1'b1;
      end else begin
        valid_d  = 1'b0;
      end
    end else begin
      case (state_q)
        ACCUM: begin
          if (sum_valid_i) begin
            accum_d = add_res;
            cnt_d   = cnt_inc;
            if (cnt_inc == num_q) begin
              result_d = add_res;
              valid_d  = 1'b1;
            end
          end
        end
        DONE: begin
          if (sum_valid_i) err_d = 1'b1;
          if (xfer) valid_d = 1'b0;
        end
        default: begin
          if (sum_valid_i) err_d = 1'b1;
        end
      endcase
    end
  end

  assign acc_o       = result_q;
  assign acc_valid_o = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_sum_accum_12.sv
// Randomized scoreboard bench for sum_accum_12: two instances (ACC_W=20 and 13)
// share stimulus; each frame's expected result comes from plain integer arithmetic.
module tb_sum_accum_12;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  num_terms_i = '0;
  logic [11:0] sum_i = '0;
  logic        sum_valid_i = 1'b0;
  logic        acc_ready_i = 1'b0;

  logic [19:0] acc20;
  logic        v20, busy20, err20;
  logic [12:0] acc13;
  logic        v13, busy13, err13;

  int n_vec = 0;
  int n_err = 0;

  logic [11:0] terms_q[$];
  logic [31:0] exp20_q[$];
  logic [31:0] exp13_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  sum_accum_12 #(.ACC_W(20)) u_dut20 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_terms_i(num_terms_i),
    .sum_i(sum_i), .sum_valid_i(sum_valid_i), .acc_o(acc20), .acc_valid_o(v20),
    .acc_ready_i(acc_ready_i), .busy_o(busy20), .err_o(err20)
  );

  sum_accum_12 #(.ACC_W(13)) u_dut13 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .num_terms_i(num_terms_i),
    .sum_i(sum_i), .sum_valid_i(sum_valid_i), .acc_o(acc13), .acc_valid_o(v13),
    .acc_ready_i(acc_ready_i), .busy_o(busy13), .err_o(err13)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model(input longint tot, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
`ifdef SUM_ACCUM_SAT_EN
    return (tot > mx) ? 32'(mx) : 32'(tot);
`else
    return 32'(tot & mx);
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    exp20_q.delete();
    exp13_q.delete();
  endtask

  task automatic plan_random(input int n);
    terms_q.delete();
    for (int i = 0; i < n; i++) terms_q.push_back(12'($urandom));
  endtask

  task automatic push_expected();
    longint tot = 0;
    foreach (terms_q[i]) tot += longint'(terms_q[i]);
    exp20_q.push_back(model(tot, 20));
    exp13_q.push_back(model(tot, 13));
  endtask

  task automatic drive_start();
    start_i     = 1'b1;
    num_terms_i = 8'(terms_q.size());
    tick();
    start_i     = 1'b0;
    num_terms_i = 8'($urandom);
  endtask

  task automatic send_terms(input int gap_min, input int gap_max);
    int n = terms_q.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(gap_min, gap_max)) begin
        start_i = 1'($urandom);
        tick();
      end
      if (i == n - 1) begin
        check("pre_last_valid20", 32'(v20), 32'd0);
        check("pre_last_valid13", 32'(v13), 32'd0);
      end
      start_i     = 1'($urandom);
      sum_valid_i = 1'b1;
      sum_i       = terms_q[i];
      tick();
      sum_valid_i = 1'b0;
      sum_i       = 12'($urandom);
    end
    start_i = 1'b0;
    check("latency_valid20", 32'(v20), 32'd1);
    check("latency_valid13", 32'(v13), 32'd1);
    check("done_busy20", 32'(busy20), 32'd1);
    terms_q.delete();
  endtask

  // Holds ready low for hold cycles (with ignored start pulses), then accepts,
  // optionally starting the already-planned next frame in the same cycle.
  task automatic accept(input int hold, input bit nxt, input bit stray);
    repeat (hold) begin
      start_i = 1'($urandom);
      tick();
    end
    acc_ready_i = 1'b1;
    start_i     = nxt;
    num_terms_i = 8'(terms_q.size());
    sum_valid_i = stray;
    tick();
    acc_ready_i = 1'b0;
    start_i     = 1'b0;
    sum_valid_i = 1'b0;
    if (nxt) begin
      check("b2b_busy20", 32'(busy20), 32'd1);
      check("b2b_valid20", 32'(v20), 32'(terms_q.size() == 0));
      check("b2b_err20", 32'(err20), 32'd0);
    end else begin
      check("xfer_valid20", 32'(v20), 32'd0);
      check("xfer_busy20", 32'(busy20), 32'd0);
      check("xfer_busy13", 32'(busy13), 32'd0);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic        pv20 = 1'b0, px20 = 1'b0, pv13 = 1'b0, px13 = 1'b0;
  logic [19:0] pa20 = '0;
  logic [12:0] pa13 = '0;

  always @(negedge clk) begin
    if (rst_i) begin
      pv20 = 1'b0;
      pv13 = 1'b0;
    end else begin
      if (pv20 && !px20) begin
        check("hold_valid20", 32'(v20), 32'd1);
        check("hold_acc20", 32'(acc20), 32'(pa20));
      end
      if (pv13 && !px13) begin
        check("hold_valid13", 32'(v13), 32'd1);
        check("hold_acc13", 32'(acc13), 32'(pa13));
      end
      if (v20 && acc_ready_i) begin
        check("xfer_pending20", 32'(exp20_q.size() > 0), 32'd1);
        if (exp20_q.size() > 0) check("acc20", 32'(acc20), exp20_q.pop_front());
      end
      if (v13 && acc_ready_i) begin
        check("xfer_pending13", 32'(exp13_q.size() > 0), 32'd1);
        if (exp13_q.size() > 0) check("acc13", 32'(acc13), exp13_q.pop_front());
      end
      pv20 = v20; pa20 = acc20; px20 = v20 && acc_ready_i;
      pv13 = v13; pa13 = acc13; px13 = v13 && acc_ready_i;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit started;
    int n;
    do_reset();
    check("rst_acc20", 32'(acc20), 32'd0);
    check("rst_valid20", 32'(v20), 32'd0);
    check("rst_busy20", 32'(busy20), 32'd0);
    check("rst_err20", 32'(err20), 32'd0);

    // basic frame
    terms_q = '{12'h010, 12'h020, 12'h030, 12'h040};
    push_expected();
    drive_start();
    send_terms(0, 0);
    accept(0, 1'b0, 1'b0);

    // overrun in IDLE, sticky, cleared by start
    tick();
    sum_valid_i = 1'b1;
    tick();
    sum_valid_i = 1'b0;
    check("idle_err20", 32'(err20), 32'd1);
    repeat (3) tick();
    check("sticky_err20", 32'(err20), 32'd1);
    check("sticky_err13", 32'(err13), 32'd1);
    terms_q = '{12'hFF0, 12'hFF0, 12'hFF0};
    push_expected();
    drive_start();
    check("start_clr_err20", 32'(err20), 32'd0);
    send_terms(2, 2);
    accept(5, 1'b0, 1'b0);

    // back-to-back with a zero-term frame
    plan_random(2);
    push_expected();
    drive_start();
    send_terms(0, 1);
    terms_q.delete();
    push_expected();
    accept(1, 1'b1, 1'b0);
    accept(2, 1'b0, 1'b0);

    // stray term in DONE, then start+stray in the transfer cycle
    plan_random(1);
    push_expected();
    drive_start();
    send_terms(0, 0);
    sum_valid_i = 1'b1;
    tick();
    sum_valid_i = 1'b0;
    check("done_err20", 32'(err20), 32'd1);
    check("done_valid20", 32'(v20), 32'd1);
    plan_random(3);
    push_expected();
    accept(1, 1'b1, 1'b1);
    send_terms(0, 2);
    accept(0, 1'b0, 1'b0);

    // mid-frame reset
    plan_random(4);
    drive_start();
    for (int i = 0; i < 2; i++) begin
      sum_valid_i = 1'b1;
      sum_i = terms_q[i];
      tick();
    end
    sum_valid_i = 1'b0;
    terms_q.delete();
    rst_i = 1'b1;
    start_i = 1'b1;
    sum_valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    start_i = 1'b0;
    sum_valid_i = 1'b0;
    check("mid_rst_acc20", 32'(acc20), 32'd0);
    check("mid_rst_valid20", 32'(v20), 32'd0);
    check("mid_rst_busy20", 32'(busy20), 32'd0);
    check("mid_rst_err20", 32'(err20), 32'd0);
    terms_q = '{12'h100};
    push_expected();
    drive_start();
    send_terms(0, 0);
    accept(0, 1'b0, 1'b0);

    // randomized frames
    started = 1'b0;
    for (int f = 0; f < 40; f++) begin
      if (!started) begin
        n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
        if ($urandom_range(0, 9) == 0) n = 20;
        plan_random(n);
        push_expected();
        drive_start();
      end
      send_terms(0, $urandom_range(0, 2));
      if ((f < 39) && ($urandom_range(0, 1) == 1)) begin
        plan_random(($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 6));
        push_expected();
        accept($urandom_range(0, 4), 1'b1, 1'b0);
        started = 1'b1;
      end else begin
        accept($urandom_range(0, 4), 1'b0, 1'b0);
        started = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
    end

    repeat (3) tick();
    check("drain20", 32'(exp20_q.size()), 32'd0);
    check("drain13", 32'(exp13_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
